// File: rtl/uart_pkg.sv
// Shared definitions for the UART boot loader slice.
// Contents:
//   - UART register offsets (RX, TX, CONF).
//   - Bit positions inside the RX register word.
//   - Acknowledge codes sent back over TX.
//   - Parser and APB sequencer state encodings.
package uart_pkg;

    localparam logic [3:0] UART_RX_ADDR   = 4'h0;
    localparam logic [3:0] UART_TX_ADDR   = 4'h4;
    localparam logic [3:0] UART_CONF_ADDR = 4'h8;

    localparam int RX_EMPTY_BIT = 31;
    localparam int RX_ERR_BIT   = 9;
    localparam int RX_PAR_BIT   = 8;

    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    // ST_ACK is only reachable when the TX acknowledge write is built in.
    typedef enum logic [2:0] {
        ST_HUNT,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ACK
    } parse_state_t;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_state_t;

endpackage

// File: rtl/apb_byte_master.sv
// APB3 single-transfer sequencer.
// A transfer starts when req is high while the sequencer is idle; done pulses
// for one cycle after PREADY with the captured RX byte and flags. Requests are
// ignored during the done cycle, so the requester can react to the result
// before the next transfer, and at least one idle bus cycle separates transfers.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req, wr, addr, wdata  transfer request and its attributes
//   done                  one-cycle completion strobe
//   rx_byte, rx_empty, rx_err, rx_par  fields of the captured PRDATA
//   apb_*                 APB3 master interface
module apb_byte_master
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [7:0]  rx_byte,
    output logic        rx_empty,
    output logic        rx_err,
    output logic        rx_par,
    output logic [3:0]  apb_PADDR,
    output logic        apb_PSEL,
    output logic        apb_PENABLE,
    output logic        apb_PWRITE,
    output logic [31:0] apb_PWDATA,
    input  logic        apb_PREADY,
    input  logic [31:0] apb_PRDATA
);

    apb_state_t  state_reg, state_next;
    logic [3:0]  paddr_reg;
    logic        pwrite_reg;
    logic [31:0] pwdata_reg;
    logic        done_reg;
    logic [7:0]  rx_byte_reg;
    logic        rx_empty_reg, rx_err_reg, rx_par_reg;
    logic        prdata_unused;

    // Status bits between the flags and the empty bit carry no information.
    assign prdata_unused = &{1'b0, apb_PRDATA[30:10]};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            APB_IDLE:   if (req && !done_reg) state_next = APB_SETUP;
            APB_SETUP:  state_next = APB_ACCESS;
            APB_ACCESS: if (apb_PREADY) state_next = APB_IDLE;
            default:    state_next = APB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= APB_IDLE;
            paddr_reg    <= '0;
            pwrite_reg   <= 1'b0;
            pwdata_reg   <= '0;
            done_reg     <= 1'b0;
            rx_byte_reg  <= '0;
            rx_empty_reg <= 1'b1;
            rx_err_reg   <= 1'b0;
            rx_par_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_reg == APB_ACCESS) && apb_PREADY;
            if (state_reg == APB_IDLE && req && !done_reg) begin
                paddr_reg  <= addr;
                pwrite_reg <= wr;
                pwdata_reg <= wdata;
            end
            if (state_reg == APB_ACCESS && apb_PREADY) begin
                rx_byte_reg  <= apb_PRDATA[7:0];
                rx_empty_reg <= apb_PRDATA[RX_EMPTY_BIT];
                rx_err_reg   <= apb_PRDATA[RX_ERR_BIT];
                rx_par_reg   <= apb_PRDATA[RX_PAR_BIT];
            end
        end
    end

    assign apb_PSEL    = (state_reg != APB_IDLE);
    assign apb_PENABLE = (state_reg == APB_ACCESS);
    assign apb_PADDR   = paddr_reg;
    assign apb_PWRITE  = pwrite_reg;
    assign apb_PWDATA  = pwdata_reg;
    assign done        = done_reg;
    assign rx_byte     = rx_byte_reg;
    assign rx_empty    = rx_empty_reg;
    assign rx_err      = rx_err_reg;
    assign rx_par      = rx_par_reg;

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: polls the UART RX register over APB, parses the frame
// MAGIC, ADDR(4, LE), LEN(2, LE, words), LEN*4 data bytes, CSUM
// and writes each assembled word to memory through a valid/ready port.
// boot_done (sticky) and boot_addr report a good frame; boot_error pulses
// on a checksum mismatch, a flagged RX byte or an inter-byte timeout.
// Optional macro UART_BOOT_LOADER_ACK_EN: after each frame verdict an APB
// write of ACK/NAK to the TX register is issued; without it the loader
// never writes over APB.
// Ports:
//   clk, reset, enable     clock, synchronous active-high reset, run enable
//   apb_*                  APB3 master towards the UART controller
//   mem_valid/ready/addr/wdata  memory write port
//   boot_done, boot_error, boot_addr  status towards boot logic
module uart_boot_loader
    import uart_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000,
    parameter logic [7:0]  MAGIC          = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [3:0]  apb_PADDR,
    output logic        apb_PSEL,
    output logic        apb_PENABLE,
    output logic        apb_PWRITE,
    output logic [31:0] apb_PWDATA,
    input  logic        apb_PREADY,
    input  logic [31:0] apb_PRDATA,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        boot_done,
    output logic        boot_error,
    output logic [31:0] boot_addr
);

    parse_state_t state_reg, state_next;
    logic [31:0] addr_reg, addr_next;
    logic [15:0] len_reg, len_next;
    logic [23:0] word_reg, word_next;
    logic [15:0] idx_reg, idx_next;
    logic [1:0]  cnt_reg, cnt_next;
    logic [7:0]  sum_reg, sum_next;
    logic [23:0] timer_reg, timer_next;
    logic        mem_valid_reg, mem_valid_next;
    logic [31:0] mem_addr_reg, mem_addr_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;
    logic        boot_done_reg, boot_done_next;
    logic        boot_error_reg, boot_error_next;
    logic [31:0] boot_addr_reg, boot_addr_next;

    logic        m_req, m_wr, rx_done, rx_empty, rx_err, rx_par;
    logic [3:0]  m_addr;
    logic [31:0] m_wdata;
    logic [7:0]  rx_byte;
    logic        fetch_rd, got_byte, bad_byte, counting, fail, pass;

    // Reads stop while a word waits for memory, so no byte is lost.
    assign fetch_rd = enable && !mem_valid_reg &&
                      (state_reg inside {ST_HUNT, ST_ADDR, ST_LEN, ST_DATA, ST_CSUM});
    // A completed write is not a received byte, whatever PRDATA held.
    assign got_byte = rx_done && !rx_empty && !apb_PWRITE;
    assign bad_byte = rx_err || rx_par;
    assign counting = !mem_valid_reg &&
                      (state_reg inside {ST_ADDR, ST_LEN, ST_DATA, ST_CSUM});

`ifdef UART_BOOT_LOADER_ACK_EN
    logic [7:0] ack_code_reg, ack_code_next;
    assign m_wr    = (state_reg == ST_ACK);
    assign m_req   = fetch_rd || (enable && m_wr);
    assign m_addr  = m_wr ? UART_TX_ADDR : UART_RX_ADDR;
    assign m_wdata = {24'd0, ack_code_reg};
`else
    assign m_wr    = 1'b0;
    assign m_req   = fetch_rd;
    assign m_addr  = UART_RX_ADDR;
    assign m_wdata = '0;
`endif

    apb_byte_master u_apb (
        .clk         (clk),
        .reset       (reset),
        .req         (m_req),
        .wr          (m_wr),
        .addr        (m_addr),
        .wdata       (m_wdata),
        .done        (rx_done),
        .rx_byte     (rx_byte),
        .rx_empty    (rx_empty),
        .rx_err      (rx_err),
        .rx_par      (rx_par),
        .apb_PADDR   (apb_PADDR),
        .apb_PSEL    (apb_PSEL),
        .apb_PENABLE (apb_PENABLE),
        .apb_PWRITE  (apb_PWRITE),
        .apb_PWDATA  (apb_PWDATA),
        .apb_PREADY  (apb_PREADY),
        .apb_PRDATA  (apb_PRDATA)
    );

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        len_next        = len_reg;
        word_next       = word_reg;
        idx_next        = idx_reg;
        cnt_next        = cnt_reg;
        sum_next        = sum_reg;
        timer_next      = timer_reg;
        mem_valid_next  = mem_valid_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        boot_done_next  = boot_done_reg;
        boot_error_next = 1'b0;
        boot_addr_next  = boot_addr_reg;
`ifdef UART_BOOT_LOADER_ACK_EN
        ack_code_next   = ack_code_reg;
`endif
        fail = 1'b0;
        pass = 1'b0;

        if (mem_valid_reg && mem_ready) mem_valid_next = 1'b0;
        if (counting) timer_next = timer_reg + 24'd1;

        if (!enable) begin
            // Bytes completing while disabled are dropped; DONE is terminal.
            timer_next = '0;
            cnt_next   = '0;
            if (state_reg != ST_DONE) state_next = ST_HUNT;
        end else if (got_byte) begin
            timer_next = '0;
            if (bad_byte) begin
                if (state_reg inside {ST_ADDR, ST_LEN, ST_DATA, ST_CSUM}) fail = 1'b1;
            end else begin
                case (state_reg)
                    ST_HUNT: if (rx_byte == MAGIC) begin
                        sum_next   = '0;
                        cnt_next   = '0;
                        state_next = ST_ADDR;
                    end
                    ST_ADDR: begin
                        addr_next[{cnt_reg, 3'b000} +: 8] = rx_byte;
                        sum_next = sum_reg + rx_byte;
                        cnt_next = cnt_reg + 2'd1;
                        if (cnt_reg == 2'd3) state_next = ST_LEN;
                    end
                    ST_LEN: begin
                        sum_next = sum_reg + rx_byte;
                        if (cnt_reg == 2'd0) begin
                            len_next[7:0] = rx_byte;
                            cnt_next      = 2'd1;
                        end else begin
                            len_next[15:8] = rx_byte;
                            cnt_next       = '0;
                            idx_next       = '0;
                            state_next     = ({rx_byte, len_reg[7:0]} == 16'd0) ? ST_CSUM : ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        sum_next = sum_reg + rx_byte;
                        cnt_next = cnt_reg + 2'd1;
                        case (cnt_reg)
                            2'd0: word_next[7:0]   = rx_byte;
                            2'd1: word_next[15:8]  = rx_byte;
                            2'd2: word_next[23:16] = rx_byte;
                            default: begin
                                mem_valid_next = 1'b1;
                                mem_addr_next  = {addr_reg[31:2], 2'b00} + {14'd0, idx_reg, 2'b00};
                                mem_wdata_next = {rx_byte, word_reg};
                                idx_next       = idx_reg + 16'd1;
                                if (idx_reg + 16'd1 == len_reg) state_next = ST_CSUM;
                            end
                        endcase
                    end
                    ST_CSUM: if (rx_byte == sum_reg) pass = 1'b1; else fail = 1'b1;
                    default: ;
                endcase
            end
        end else if (counting && timer_reg == TIMEOUT_CYCLES - 24'd1) begin
            fail = 1'b1;
        end

`ifdef UART_BOOT_LOADER_ACK_EN
        // Leave ST_ACK only on completion of our own TX write.
        if (enable && state_reg == ST_ACK && rx_done && apb_PWRITE) begin
            if (ack_code_reg == ACK) begin
                state_next     = ST_DONE;
                boot_done_next = 1'b1;
            end else begin
                state_next = ST_HUNT;
            end
        end
`endif

        if (fail) begin
            boot_error_next = 1'b1;
            timer_next      = '0;
`ifdef UART_BOOT_LOADER_ACK_EN
            ack_code_next = NAK;
            state_next    = ST_ACK;
`else
            state_next = ST_HUNT;
`endif
        end
        if (pass) begin
            boot_addr_next = addr_reg;
`ifdef UART_BOOT_LOADER_ACK_EN
            ack_code_next = ACK;
            state_next    = ST_ACK;
`else
            boot_done_next = 1'b1;
            state_next     = ST_DONE;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_HUNT;
            addr_reg       <= '0;
            len_reg        <= '0;
            word_reg       <= '0;
            idx_reg        <= '0;
            cnt_reg        <= '0;
            sum_reg        <= '0;
            timer_reg      <= '0;
            mem_valid_reg  <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            boot_done_reg  <= 1'b0;
            boot_error_reg <= 1'b0;
            boot_addr_reg  <= '0;
`ifdef UART_BOOT_LOADER_ACK_EN
            ack_code_reg   <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            len_reg        <= len_next;
            word_reg       <= word_next;
            idx_reg        <= idx_next;
            cnt_reg        <= cnt_next;
            sum_reg        <= sum_next;
            timer_reg      <= timer_next;
            mem_valid_reg  <= mem_valid_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            boot_done_reg  <= boot_done_next;
            boot_error_reg <= boot_error_next;
            boot_addr_reg  <= boot_addr_next;
`ifdef UART_BOOT_LOADER_ACK_EN
            ack_code_reg   <= ack_code_next;
`endif
        end
    end

    assign mem_valid  = mem_valid_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign boot_done  = boot_done_reg;
    assign boot_error = boot_error_reg;
    assign boot_addr  = boot_addr_reg;

endmodule
